// File: rtl/rotation_pkg.sv
// Shared types and constants for the two-sensor rotation decoder.
package rotation_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEN_A = 2'd1,
    SEEN_B = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/sensor_edge_sync.sv
// Synchronizes one asynchronous sensor level and emits a registered one-cycle
// pulse per rising edge; a level already high when reset releases is not a rise.
module sensor_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sensor,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_prev;
  logic                   r_armed;
  logic                   r_rise;
  logic                   w_level;

  assign w_level = r_sync[SYNC_STAGES-1];

  // r_fill marks when the chain holds real samples; arming waits for a genuine low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_fill  <= '0;
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the previous
      // stage's old value, which is what makes this a shift chain.
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sensor};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_prev <= w_level;
      if (r_fill[SYNC_STAGES-1] && !w_level) begin
        r_armed <= 1'b1;
      end
      r_rise <= r_armed & w_level & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/rotation_decoder.sv
// Two-sensor pass decoder: A then B counts left (+1), B then A counts right (-1).
// Define ROTATION_DECODER_TIMEOUT_EN to abandon a half-finished pass after TIMEOUT cycles.
module rotation_decoder
  import rotation_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sensorA,
  input  logic                    sensorB,
  output logic signed [CNT_W-1:0] pos,
  output logic                    dir,
  output logic                    step_valid,
  output logic                    err,
  output logic                    busy
);

  state_t                   r_state, w_state_nxt;
  logic signed [CNT_W-1:0]  r_pos, w_pos_nxt;
  logic                     r_dir, w_dir_nxt;
  logic                     r_step, w_step_nxt;
  logic                     r_err, w_err_nxt;
  logic                     w_rise_a, w_rise_b;
  logic                     w_timeout;

  sensor_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk      (clk),
    .rst      (rst),
    .i_sensor (sensorA),
    .o_rise   (w_rise_a)
  );

  sensor_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk      (clk),
    .rst      (rst),
    .i_sensor (sensorB),
    .o_rise   (w_rise_b)
  );

`ifdef ROTATION_DECODER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] r_to_cnt;

  assign w_timeout = (r_state != IDLE) && (r_to_cnt == TO_W'(TIMEOUT - 1));

  // Counts cycles spent waiting for the second sensor; any rise restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state == IDLE || w_rise_a || w_rise_b || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  // Constant false for any legal TIMEOUT: a pass may wait forever.
  assign w_timeout = (TIMEOUT < 1);
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_dir_nxt   = r_dir;
    w_step_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rise_a && w_rise_b) begin
          w_err_nxt = 1'b1;
        end else if (w_rise_a) begin
          w_state_nxt = SEEN_A;
        end else if (w_rise_b) begin
          w_state_nxt = SEEN_B;
        end
      end
      SEEN_A: begin
        if (w_rise_a && w_rise_b) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_rise_b) begin
          w_step_nxt  = 1'b1;
          w_dir_nxt   = DIR_LEFT;
          w_pos_nxt   = r_pos + CNT_W'(1);
          w_state_nxt = IDLE;
        end else if (!w_rise_a && w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      SEEN_B: begin
        if (w_rise_a && w_rise_b) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_rise_a) begin
          w_step_nxt  = 1'b1;
          w_dir_nxt   = DIR_RIGHT;
          w_pos_nxt   = r_pos - CNT_W'(1);
          w_state_nxt = IDLE;
        end else if (!w_rise_b && w_timeout) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pos   <= '0;
      r_dir   <= DIR_RIGHT;
      r_step  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_dir   <= w_dir_nxt;
      r_step  <= w_step_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign pos        = r_pos;
  assign dir        = r_dir;
  assign step_valid = r_step;
  assign err        = r_err;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_rotation_decoder.sv
// Self-checking bench for rotation_decoder: a 16-bit and a 4-bit instance share
// stimulus; a pass-level model predicts every registered output.
module tb_rotation_decoder;

  localparam int S = 2;
`ifdef ROTATION_DECODER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sensorA = 1'b0;
  logic        sensorB = 1'b0;
  logic [15:0] pos;
  logic        dir, step_valid, err, busy;
  logic [3:0]  pos_s;
  logic        dir_s, step_valid_s, err_s, busy_s;

  rotation_decoder #(.CNT_W(16), .SYNC_STAGES(S), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .sensorA(sensorA), .sensorB(sensorB),
    .pos(pos), .dir(dir), .step_valid(step_valid), .err(err), .busy(busy)
  );

  rotation_decoder #(.CNT_W(4), .SYNC_STAGES(S), .TIMEOUT(TO)) dut_small (
    .clk(clk), .rst(rst), .sensorA(sensorA), .sensorB(sensorB),
    .pos(pos_s), .dir(dir_s), .step_valid(step_valid_s), .err(err_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pass-level model: pending first sensor (0 none, 1 A, 2 B), unbounded position.
  int   m_pos  = 0;
  logic m_dir  = 1'b0;
  int   m_pend = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic exp_sv, input logic exp_err);
    check({tag, ".step_valid"}, 32'(step_valid), 32'(exp_sv));
    check({tag, ".err"},        32'(err),        32'(exp_err));
    check({tag, ".pos"},        32'(pos),        32'(m_pos & 'hFFFF));
    check({tag, ".dir"},        32'(dir),        32'(m_dir));
    check({tag, ".busy"},       32'(busy),       32'(m_pend != 0));
    check({tag, ".s_step"},     32'(step_valid_s), 32'(exp_sv));
    check({tag, ".s_err"},      32'(err_s),      32'(exp_err));
    check({tag, ".s_pos"},      32'(pos_s),      32'(m_pos & 'hF));
    check({tag, ".s_dir"},      32'(dir_s),      32'(m_dir));
    check({tag, ".s_busy"},     32'(busy_s),     32'(m_pend != 0));
  endtask

  task automatic model_event(input logic a, input logic b, output logic exp_sv, output logic exp_err);
    exp_sv  = 1'b0;
    exp_err = 1'b0;
    if (a && b) begin
      exp_err = 1'b1;
      m_pend  = 0;
    end else if (a) begin
      if (m_pend == 2) begin
        exp_sv = 1'b1; m_dir = 1'b0; m_pos = m_pos - 1; m_pend = 0;
      end else begin
        m_pend = 1;
      end
    end else if (b) begin
      if (m_pend == 1) begin
        exp_sv = 1'b1; m_dir = 1'b1; m_pos = m_pos + 1; m_pend = 0;
      end else begin
        m_pend = 2;
      end
    end
  endtask

  // Raise the selected sensors, check exact output latency and pulse width, then release.
  task automatic pulse(input logic a, input logic b, input int low, input string tag);
    logic esv, eerr;
    @(negedge clk);
    if (a) sensorA = 1'b1;
    if (b) sensorB = 1'b1;
    model_event(a, b, esv, eerr);
    repeat (S + 1) @(posedge clk);
    #1;
    check({tag, ".early_step"}, 32'(step_valid), 32'd0);
    check({tag, ".early_err"},  32'(err),        32'd0);
    @(posedge clk);
    #1;
    check_outputs(tag, esv, eerr);
    @(posedge clk);
    #1;
    check({tag, ".step_cleared"}, 32'(step_valid), 32'd0);
    check({tag, ".err_cleared"},  32'(err),        32'd0);
    @(negedge clk);
    if (a) sensorA = 1'b0;
    if (b) sensorB = 1'b0;
    repeat (low) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_err;
    int exp_first_err;
    int r;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Left pass: A, then B ten cycles later
    pulse(1'b1, 1'b0, 4, "a_first");
    pulse(1'b0, 1'b1, 4, "left_pass");
    check("left_pos_one", 32'(pos), 32'h1);

    // Two right passes: 1 -> 0 -> -1
    pulse(1'b0, 1'b1, 4, "b_first_1");
    pulse(1'b1, 1'b0, 4, "right_pass_1");
    pulse(1'b0, 1'b1, 4, "b_first_2");
    pulse(1'b1, 1'b0, 4, "right_pass_2");
    check("pos_ffff", 32'(pos), 32'hFFFF);

    // Simultaneous rises in IDLE and in SEEN_A
    pulse(1'b1, 1'b1, 4, "both_idle");
    pulse(1'b1, 1'b0, 4, "a_before_both");
    pulse(1'b1, 1'b1, 4, "both_seen_a");
    check("both_pos_kept", 32'(pos), 32'hFFFF);

    // Repeated A rise keeps SEEN_A, then B completes: -1 -> 0
    pulse(1'b1, 1'b0, 3, "repeat_a_1");
    pulse(1'b1, 1'b0, 3, "repeat_a_2");
    pulse(1'b0, 1'b1, 3, "repeat_a_done");

    // Wrap of the 4-bit instance: 7 + 1 -> -8
    for (int i = 0; i < 7; i++) begin
      pulse(1'b1, 1'b0, 2, "wrap_a");
      pulse(1'b0, 1'b1, 2, "wrap_b");
    end
    check("small_pos_7", 32'(pos_s), 32'h7);
    pulse(1'b1, 1'b0, 2, "wrap_last_a");
    pulse(1'b0, 1'b1, 2, "wrap_last_b");
    check("small_pos_wrap", 32'(pos_s), 32'h8);
    check("big_pos_8", 32'(pos), 32'h8);

    // Pass left open: timeout build aborts after TO cycles, otherwise waits
    first_err = -1;
    @(negedge clk);
    sensorA = 1'b1;
    m_pend = 1;
    repeat (S + 2) @(posedge clk);
    #1;
    check("to_entry_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (err === 1'b1 && first_err < 0) first_err = k;
    end
`ifdef ROTATION_DECODER_TIMEOUT_EN
    exp_first_err = 16;
    m_pend = 0;
`else
    exp_first_err = -1;
`endif
    check("timeout_err_cycle", 32'(first_err), 32'(exp_first_err));
    check("timeout_busy", 32'(busy), 32'(m_pend != 0));
    @(negedge clk);
    sensorA = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during SEEN_A with A held high; B then enters SEEN_B, A ignored until it cycles
    @(negedge clk);
    sensorA = 1'b1;
    m_pend = 1;
    repeat (S + 2) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    m_pos = 0; m_dir = 1'b0; m_pend = 0;
    @(posedge clk);
    #1;
    check_outputs("mid_pass_reset", 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_outputs("held_a_ignored", 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1, "b_after_reset");
    check("after_reset_busy", 32'(busy), 32'd1);
    sensorA = 1'b0;
    repeat (3) @(negedge clk);
    pulse(1'b1, 1'b0, 3, "a_completes_right");
    check("after_reset_pos", 32'(pos), 32'hFFFF);

    // Random sensor traffic against the model
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 8);
      if (r == 0)      pulse(1'b1, 1'b1, $urandom_range(2, 6), "rand_both");
      else if (r <= 4) pulse(1'b1, 1'b0, $urandom_range(2, 6), "rand_a");
      else             pulse(1'b0, 1'b1, $urandom_range(2, 6), "rand_b");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rotation_decoder.md
ROTATION_DECODER -- requirements
Module: rotation_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the signed position counter.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops per sensor input (minimum 2).
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum number of cycles between the first and second sensor of one pass.
REQ-004 SHALL have port clk  input  1  single clock for all state; everything on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sensorA  input  1  asynchronous level from sensor A (mark at position 23).
REQ-007 SHALL have port sensorB  input  1  asynchronous level from sensor B (mark at position 7).
REQ-008 SHALL have port pos  output  CNT_W  signed two's-complement count of completed passes.
REQ-009 SHALL have port dir  output  1  direction of the last completed pass (1 = left, 0 = right).
REQ-010 SHALL have port step_valid  output  1  one-cycle pulse when a pass completes.
REQ-011 SHALL have port err  output  1  one-cycle pulse on an illegal or timed-out sequence.
REQ-012 SHALL have port busy  output  1  high while a pass is in progress (state not IDLE).

Function
REQ-013 SHALL pass each sensor through SYNC_STAGES flops, then detect rising edges against one further registered copy.
REQ-014 SHALL implement FSM states IDLE, SEEN_A and SEEN_B.
REQ-015 SHALL, in IDLE, go to SEEN_A on an A rise alone, go to SEEN_B on a B rise alone, and pulse err and stay IDLE on simultaneous rises.
REQ-016 SHALL, in SEEN_A, on a B rise alone, pulse step_valid, set dir=1, increment pos, and return to IDLE.
REQ-017 SHALL, in SEEN_B, on an A rise alone, pulse step_valid, set dir=0, decrement pos, and return to IDLE.
REQ-018 SHALL, on a repeat rise of the same sensor in SEEN_A or SEEN_B, stay in that state and clear the timeout counter, with no err.
REQ-019 SHALL, on simultaneous A and B rises in SEEN_A or SEEN_B, pulse err, return to IDLE, and leave pos and dir unchanged.
REQ-020 SHALL wrap pos modulo 2^CNT_W (0x7FFF+1 gives 0x8000; 0x8000-1 gives 0x7FFF at the default width), with no saturation and no err.
REQ-021 SHALL register step_valid, err, pos and dir, asserting them SYNC_STAGES+1 clock edges after the first edge that samples the completing sensor high.
REQ-022 SHALL ignore falling edges and sensor levels; only rising edges act.
REQ-023 SHALL never assert step_valid and err in the same cycle.

Reset
REQ-024 SHALL, while rst is high, force: state IDLE, pos 0, dir 0, step_valid 0, err 0, busy 0, timeout counter 0, and all synchronizer and edge flops 0.
REQ-025 SHALL, on reset mid-pass, abandon the pass with no step_valid or err.
REQ-026 SHALL, after reset release, not treat a sensor already high as a rise until it goes low and high again.

Configuration
REQ-027 SHALL use the macro ROTATION_DECODER_TIMEOUT_EN to enable the timeout.
REQ-028 SHALL, with ROTATION_DECODER_TIMEOUT_EN defined, count cycles in SEEN_A or SEEN_B, and when the count reaches TIMEOUT with no completing rise, pulse err and return to IDLE.
REQ-029 SHALL, without ROTATION_DECODER_TIMEOUT_EN, include no timeout counter and allow SEEN_A and SEEN_B to persist indefinitely; TIMEOUT is then unused.

Structure
REQ-030 SHALL place the state enum (IDLE, SEEN_A, SEEN_B), the DIR_LEFT=1 and DIR_RIGHT=0 constants, and the default CNT_W in the shared package rotation_pkg.
REQ-031 SHALL implement synchronizer plus rise detection as sub-module sensor_edge_sync, parameterised by SYNC_STAGES and instantiated once per sensor.
REQ-032 SHALL keep the FSM, position counter and timeout counter in rotation_decoder.

Verification
REQ-033 SHALL cover: reset, then A rise, then B rise 10 cycles later -> one step_valid, dir=1, pos=1, SYNC_STAGES+1 edges after B is first sampled high.
REQ-034 SHALL cover: from pos=1, B rise then A rise -> step_valid, dir=0, pos=0; then a second B-then-A pass -> pos=0xFFFF.
REQ-035 SHALL cover: A and B rising on the same clk edge, in IDLE and in SEEN_A -> err pulse, pos unchanged, busy low the next cycle.
REQ-036 SHALL cover: pos preloaded to 0x7FFF through repeated left passes (CNT_W=4 for speed: 7), one more left pass -> pos=0x8 (-8), no err.
REQ-037 SHALL cover, with ROTATION_DECODER_TIMEOUT_EN and TIMEOUT=16: A rise with no B -> err exactly 16 cycles after SEEN_A entry; without the macro, no err and busy stays high.
REQ-038 SHALL cover: rst asserted for one cycle in SEEN_A, then a B rise -> no step_valid, FSM goes to SEEN_B, pos=0.
